// File: rtl/seg_display_ctrl.sv
// 8-digit seven-segment display controller. Latches stored words and shows them in hex or
// in blanked unsigned decimal, using a serial double-dabble converter and a time-multiplexed scan.
module seg_display_ctrl #(
  parameter int SCAN_DIV   = 50_000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        seg_ctrl,
  input  logic [31:0] seg_wdata,
  input  logic        seg_dec,
  output logic        busy,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (NUM_DIGITS != 8) begin : g_bad_digits
    $error("seg_display_ctrl supports exactly 8 digits");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg_display_ctrl needs SCAN_DIV >= 2");
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state_q, state_d;
  logic [71:0]   sh_q, sh_d;
  logic [4:0]    bit_q, bit_d;
  logic [63:0]   disp_q, disp_d;
  logic [31:0]   wdata_q;
  logic          dec_q, pend_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, out_q;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  function automatic logic [63:0] hex_glyphs(input logic [31:0] v);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) g[8*i +: 8] = glyph(v[4*i +: 4]);
    return g;
  endfunction

  // Upper two BCD digits nonzero means the value does not fit in 8 decimal digits.
  function automatic logic [63:0] dec_glyphs(input logic [39:0] bcd);
    logic [63:0] g;
    logic        lead;
    g    = {8{8'hBF}};
    lead = 1'b1;
    if (bcd[39:32] == 8'd0) begin
      for (int i = 7; i >= 0; i--) begin
        if (bcd[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
        g[8*i +: 8] = lead ? 8'hFF : glyph(bcd[4*i +: 4]);
      end
    end
    return g;
  endfunction

  function automatic logic [71:0] dd_step(input logic [71:0] s);
    logic [71:0] t;
    t = s;
    for (int i = 0; i < 10; i++) begin
      if (t[32+4*i +: 4] >= 4'd5) t[32+4*i +: 4] = t[32+4*i +: 4] + 4'd3;
    end
    return {t[70:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    disp_d  = disp_q;
    if (pend_q && !dec_q) disp_d = hex_glyphs(wdata_q);
    case (state_q)
      CONV: begin
        sh_d  = dd_step(sh_q);
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        if (!seg_ctrl) disp_d = dec_glyphs(sh_q[71:32]);
        state_d = IDLE;
      end
      default: ;
    endcase
    // A new store always wins: decimal restarts, hex aborts any conversion.
    if (seg_ctrl) begin
      if (seg_dec) begin
        state_d = CONV;
        sh_d    = {40'd0, seg_wdata};
        bit_d   = 5'd0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      disp_q  <= {8{8'hC0}};
      wdata_q <= '0;
      dec_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      out_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      disp_q  <= disp_d;
      pend_q  <= seg_ctrl;
      if (seg_ctrl) begin
        wdata_q <= seg_wdata;
        dec_q   <= seg_dec;
      end
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= ~(8'd1 << idx_d);
      out_q   <= disp_q[{idx_d, 3'b000} +: 8];
    end
  end

  assign busy    = (state_q != IDLE);
  assign seg_an  = an_q;
  assign seg_out = out_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl with a short scan period; expected digit patterns are queued
// as each store is driven and popped as the scan presents each digit.
module tb_seg_display_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        seg_ctrl = 1'b0;
  logic [31:0] seg_wdata = '0;
  logic        seg_dec = 1'b0;
  logic        busy;
  logic [7:0]  seg_an, seg_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  seg_display_ctrl #(.SCAN_DIV(DIV), .NUM_DIGITS(8)) dut (
    .clk(clk), .rstn(rstn), .seg_ctrl(seg_ctrl), .seg_wdata(seg_wdata),
    .seg_dec(seg_dec), .busy(busy), .seg_an(seg_an), .seg_out(seg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gl(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [63:0] hex_m(input logic [31:0] v);
    logic [63:0] g;
    for (int i = 0; i < 8; i++) g[8*i +: 8] = gl(int'((v >> (4*i)) & 32'hF));
    return g;
  endfunction

  function automatic logic [63:0] dec_m(input logic [31:0] v);
    logic [63:0] g;
    longint unsigned p;
    if (v > 32'd99_999_999) return {8{8'hBF}};
    p = 1;
    for (int i = 0; i < 8; i++) begin
      g[8*i +: 8] = (i == 0 || longint'(v) >= p) ? gl(int'((longint'(v) / p) % 10)) : 8'hFF;
      p = p * 10;
    end
    return g;
  endfunction

  task automatic push_display(input logic [63:0] g);
    for (int i = 0; i < 8; i++) exp_q.push_back({~(8'd1 << i), g[8*i +: 8]});
  endtask

  task automatic write(input logic [31:0] v, input logic dec);
    @(negedge clk);
    seg_ctrl = 1'b1; seg_wdata = v; seg_dec = dec;
    @(negedge clk);
    seg_ctrl = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (busy && g < 200) begin @(negedge clk); g++; end
    checks++;
    if (busy) begin errors++; $display("FAIL %s: busy still %b after %0d cycles, want 0", nm, busy, g); end
  endtask

  // Sync to the 7->0 wrap, then pop one expected entry per digit slot.
  task automatic check_display(input string nm);
    logic [15:0] got, exp;
    int hold, g;
    g = 0;
    @(negedge clk);
    while (seg_an !== 8'h7F && g < 100) begin @(negedge clk); g++; end
    while (seg_an === 8'h7F && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (g >= 100) begin
      errors++;
      $display("FAIL %s_sync: scan never wrapped, seg_an=%h want FE after 7F", nm, seg_an);
      exp_q.delete();
      return;
    end
    for (int d = 0; d < 8; d++) begin
      got = {seg_an, seg_out};
      hold = 0;
      while (seg_an === got[15:8] && hold < 100) begin
        checks++;
        if (seg_out !== got[7:0]) begin errors++; $display("FAIL %s_stable%0d: seg_out=%h want %h", nm, d, seg_out, got[7:0]); end
        @(negedge clk); hold++;
      end
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s_digit%0d: an/out=%h want %h", nm, d, got, exp); end
      checks++;
      if (hold != DIV) begin errors++; $display("FAIL %s_hold%0d: held %0d cycles want %0d", nm, d, hold, DIV); end
    end
    checks++;
    if (seg_an !== 8'hFE) begin errors++; $display("FAIL %s_wrap: seg_an=%h want FE", nm, seg_an); end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seg_an, seg_out, busy} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL reset_vals: an=%h out=%h busy=%b want FF FF 0", seg_an, seg_out, busy);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({seg_an, seg_out} !== {8'hFE, 8'hC0}) begin
      errors++; $display("FAIL reset_release: an=%h out=%h want FE C0", seg_an, seg_out);
    end
    push_display(hex_m(32'h0));
    check_display("reset_disp");
  endtask

  task automatic test_hex;
    write(32'h1234ABCD, 1'b0);
    push_display(hex_m(32'h1234ABCD));
    check_display("hex");
  endtask

  task automatic test_back_to_back;
    write(32'hDEADBEEF, 1'b0);
    write(32'h0C0FFEE5, 1'b0);
    push_display(hex_m(32'h0C0FFEE5));
    check_display("b2b_hex");
  endtask

  task automatic test_decimal;
    int t0;
    write(32'd12345, 1'b1);
    t0 = cyc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy_rise: busy=%b want 1", busy); end
    wait_idle("dec_idle");
    checks++;
    if (cyc - t0 != 33) begin errors++; $display("FAIL dec_busy_len: busy fell %0d cycles after strobe want 33", cyc - t0); end
    push_display(dec_m(32'd12345));
    check_display("dec12345");
  endtask

  task automatic test_overflow;
    logic [31:0] vals[6];
    vals[0] = 32'd100_000_000;
    vals[1] = 32'd0;
    vals[2] = 32'hFFFF_FFFF;
    vals[3] = 32'($urandom_range(99_999_999, 0));
    vals[4] = 32'($urandom_range(9_999, 0));
    vals[5] = 32'd99_999_999;
    for (int i = 0; i < 6; i++) begin
      write(vals[i], 1'b1);
      wait_idle("ovf_idle");
      push_display(dec_m(vals[i]));
      check_display($sformatf("dec_%0d", vals[i]));
    end
  endtask

  task automatic test_restart;
    int t0, g;
    logic saw_one;
    saw_one = 1'b0;
    write(32'd111, 1'b1);
    t0 = cyc;
    repeat (8) begin @(negedge clk); if (seg_out === 8'hF9) saw_one = 1'b1; end
    write(32'd987, 1'b1);
    g = 0;
    while (busy && g < 200) begin
      if (seg_out === 8'hF9) saw_one = 1'b1;
      @(negedge clk); g++;
    end
    checks++;
    if (cyc - t0 != 43) begin errors++; $display("FAIL restart_busy: busy fell %0d cycles after first strobe want 43", cyc - t0); end
    repeat (3) begin @(negedge clk); if (seg_out === 8'hF9) saw_one = 1'b1; end
    checks++;
    if (saw_one) begin errors++; $display("FAIL restart_stale: glyph F9 seen=%b want 0", saw_one); end
    push_display(dec_m(32'd987));
    check_display("restart987");
  endtask

  task automatic test_abort_reset;
    write(32'd12345678, 1'b1);
    repeat (5) @(negedge clk);
    write(32'hF, 1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: busy=%b want 0", busy); end
    push_display(hex_m(32'hF));
    check_display("abort_hex");
    write(32'd55555, 1'b1);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({seg_an, seg_out, busy} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL midconv_reset: an=%h out=%h busy=%b want FF FF 0", seg_an, seg_out, busy);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    push_display(hex_m(32'h0));
    check_display("post_reset");
    repeat (40) @(negedge clk);
    checks++;
    if (seg_out === 8'h92 || busy !== 1'b0) begin
      errors++; $display("FAIL no_partial: out=%h busy=%b want no 92 and busy 0", seg_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_back_to_back();
    test_decimal();
    test_overflow();
    test_restart();
    test_abort_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_left: %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
